// File: rtl/result_pkg.sv
// Shared constants and state encoding for the face-detection result drain.
package result_pkg;

   localparam int unsigned RESULT_W     = 12;
   localparam int unsigned COUNT_W      = 16;
   localparam int unsigned CAND_W       = 5;
   localparam int unsigned NUM_VARIABLE = 3;
   localparam int unsigned IDX_W        = $clog2(NUM_VARIABLE);

   // Word position inside one record as it leaves the result FIFO
   localparam logic [IDX_W-1:0] IDX_X    = IDX_W'(0);
   localparam logic [IDX_W-1:0] IDX_Y    = IDX_W'(1);
   localparam logic [IDX_W-1:0] IDX_CAND = IDX_W'(NUM_VARIABLE - 1);

   typedef enum logic [2:0] {
      IDLE,
      READ,
      LATCH,
      PRESENT,
      DONE
   } state_t;

endpackage

// File: rtl/result_record_reg.sv
// Record holding registers: one FIFO word is loaded into x, y or candidate per load strobe.
module result_record_reg
   import result_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = RESULT_W,
   parameter int unsigned CAND_WIDTH = CAND_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [IDX_W-1:0]      idx,
   input  logic [DATA_WIDTH-1:0] word,
   output logic [DATA_WIDTH-1:0] x,
   output logic [DATA_WIDTH-1:0] y,
   output logic [CAND_WIDTH-1:0] cand
);

   // Upper bits of the candidate word carry no information and are dropped
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x    <= '0;
         y    <= '0;
         cand <= '0;
      end else if (load) begin
         case (idx)
            IDX_X:    x    <= word;
            IDX_Y:    y    <= word;
            IDX_CAND: cand <= word[CAND_WIDTH-1:0];
            default:  ;
         endcase
      end
   end

endmodule

// File: rtl/result_reader.sv
// Drains one detection (x, y, candidate) from the result FIFO and hands it downstream
// over valid/ready, then acknowledges the store and counts delivered records.
module result_reader
   import result_pkg::*;
#(
   parameter int unsigned DATA_WIDTH_12 = RESULT_W,
   parameter int unsigned DATA_WIDTH_16 = COUNT_W,
   parameter int unsigned NUM_RESIZE    = CAND_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     ready_send_result,
   input  logic                     empty,
   input  logic [DATA_WIDTH_12-1:0] result,
   output logic                     o_trig_send_result,
   output logic                     o_result_sent,
   output logic [DATA_WIDTH_12-1:0] o_x,
   output logic [DATA_WIDTH_12-1:0] o_y,
   output logic [NUM_RESIZE-1:0]    o_candidate,
   output logic                     o_valid,
   input  logic                     ready,
   output logic [DATA_WIDTH_16-1:0] o_record_count,
   output logic                     o_busy
);

   state_t                   state_q;
   state_t                   state_d;
   logic [IDX_W-1:0]         idx_q;
   logic                     rd_req_c;
   logic                     valid_q;
   logic                     sent_q;
   logic                     busy_q;
   logic [DATA_WIDTH_16-1:0] count_q;

   // Next state; the read request must see this cycle's empty flag, so it is not registered
   always_comb begin
      state_d  = state_q;
      rd_req_c = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (ready_send_result && !empty) begin
               state_d = READ;
            end
         end
         READ: begin
            if (!empty) begin
               rd_req_c = 1'b1;
               state_d  = LATCH;
            end
         end
         LATCH: begin
            state_d = (idx_q == IDX_CAND) ? PRESENT : READ;
         end
         PRESENT: begin
            if (valid_q && ready) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register with status flags decoded from the next state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         valid_q <= 1'b0;
         sent_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         valid_q <= (state_d == PRESENT);
         sent_q  <= (state_d == DONE);
         busy_q  <= (state_d != IDLE);
      end
   end

   // Word index survives READ stalls so a partial record resumes where it left off
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx_q <= IDX_X;
      end else if (state_q == LATCH) begin
         idx_q <= (idx_q == IDX_CAND) ? IDX_X : IDX_W'(idx_q + 1'b1);
      end
   end

   // Delivered-record counter, free-running wrap
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else if (valid_q && ready) begin
         count_q <= count_q + DATA_WIDTH_16'(1);
      end
   end

   result_record_reg #(
      .DATA_WIDTH (DATA_WIDTH_12),
      .CAND_WIDTH (NUM_RESIZE)
   ) u_record (
      .clk   (clk),
      .reset (reset),
      .load  (state_q == LATCH),
      .idx   (idx_q),
      .word  (result),
      .x     (o_x),
      .y     (o_y),
      .cand  (o_candidate)
   );

   assign o_trig_send_result = rd_req_c;
   assign o_result_sent      = sent_q;
   assign o_valid            = valid_q;
   assign o_busy             = busy_q;
   assign o_record_count     = count_q;

endmodule

// File: tb/tb_result_reader.sv
// Self-checking bench for result_reader: FIFO model, vector table, corner sequences, random traffic.
module tb_result_reader;
   import result_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        ready_send_result;
   logic        empty;
   logic [11:0] result = '0;
   logic        o_trig_send_result;
   logic        o_result_sent;
   logic [11:0] o_x;
   logic [11:0] o_y;
   logic [4:0]  o_candidate;
   logic        o_valid;
   logic        ready;
   logic [15:0] o_record_count;
   logic        o_busy;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [15:0] exp_count = '0;

   always #5 clk = ~clk;

   result_reader dut (
      .clk                (clk),
      .reset              (reset),
      .ready_send_result  (ready_send_result),
      .empty              (empty),
      .result             (result),
      .o_trig_send_result (o_trig_send_result),
      .o_result_sent      (o_result_sent),
      .o_x                (o_x),
      .o_y                (o_y),
      .o_candidate        (o_candidate),
      .o_valid            (o_valid),
      .ready              (ready),
      .o_record_count     (o_record_count),
      .o_busy             (o_busy)
   );

   // Non-show-ahead FIFO: q appears the cycle after the read request
   logic [11:0] mem [0:1023];
   int          push_cnt = 0;
   int          pop_cnt  = 0;
   assign empty = (push_cnt == pop_cnt);

   always @(posedge clk) begin
      if (o_trig_send_result && !empty) begin
         result  <= mem[pop_cnt % 1024];
         pop_cnt <= pop_cnt + 1;
      end
   end

   task automatic push(input logic [11:0] w);
      mem[push_cnt % 1024] = w;
      push_cnt++;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Read-request protocol: never on empty, never two cycles in a row
   logic prev_trig = 1'b0;
   always @(negedge clk) begin
      if (o_trig_send_result) begin
         check("trig_on_empty", 32'(empty), 32'd0);
         check("trig_back_to_back", 32'(prev_trig), 32'd0);
      end
      prev_trig = o_trig_send_result;
   end

   typedef struct {
      logic [11:0] x;
      logic [11:0] y;
      logic [11:0] w2;
      int          hold;
      logic [4:0]  cand;
   } vec_t;

   vec_t vecs [6];

   // Full record from a preloaded FIFO, cycle-exact against the 9-cycle schedule
   task automatic run_record(input vec_t v, input int id);
      bit stable;
      push(v.x);
      push(v.y);
      push(v.w2);
      ready             = (v.hold == 0);
      ready_send_result = 1'b1;
      tick();
      ready_send_result = 1'b0;
      for (int c = 1; c <= 6; c++) begin
         check($sformatf("v%0d_trig_c%0d", id, c), 32'(o_trig_send_result), (c % 2 == 1) ? 32'd1 : 32'd0);
         check($sformatf("v%0d_busy_c%0d", id, c), 32'(o_busy), 32'd1);
         check($sformatf("v%0d_valid_c%0d", id, c), 32'(o_valid), 32'd0);
         tick();
      end
      check($sformatf("v%0d_valid", id), 32'(o_valid), 32'd1);
      check($sformatf("v%0d_x", id), 32'(o_x), 32'(v.x));
      check($sformatf("v%0d_y", id), 32'(o_y), 32'(v.y));
      check($sformatf("v%0d_cand", id), 32'(o_candidate), 32'(v.cand));
      check($sformatf("v%0d_count_pre", id), 32'(o_record_count), 32'(exp_count));
      if (v.hold > 0) begin
         stable = 1'b1;
         for (int h = 0; h < v.hold; h++) begin
            tick();
            if (!o_valid || o_x !== v.x || o_y !== v.y || o_candidate !== v.cand ||
                o_trig_send_result || o_result_sent || o_record_count !== exp_count)
               stable = 1'b0;
         end
         check($sformatf("v%0d_backpressure_hold", id), 32'(stable), 32'd1);
         ready = 1'b1;
      end
      tick();
      exp_count = exp_count + 16'd1;
      check($sformatf("v%0d_sent", id), 32'(o_result_sent), 32'd1);
      check($sformatf("v%0d_valid_after", id), 32'(o_valid), 32'd0);
      check($sformatf("v%0d_count", id), 32'(o_record_count), 32'(exp_count));
      tick();
      check($sformatf("v%0d_sent_once", id), 32'(o_result_sent), 32'd0);
      check($sformatf("v%0d_idle", id), 32'(o_busy), 32'd0);
      ready = 1'b0;
   endtask

   task automatic partial_underflow();
      bit stall_ok;
      push(12'h0AA);
      push(12'h0BB);
      ready             = 1'b1;
      ready_send_result = 1'b1;
      tick();
      ready_send_result = 1'b0;
      stall_ok = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         if (c >= 5 && (o_trig_send_result || o_valid || !o_busy)) stall_ok = 1'b0;
         tick();
      end
      check("underflow_stall", 32'(stall_ok), 32'd1);
      push(12'h003);
      #1;
      check("underflow_resume_read", 32'(o_trig_send_result), 32'd1);
      tick();
      tick();
      check("underflow_valid", 32'(o_valid), 32'd1);
      check("underflow_x", 32'(o_x), 32'h0AA);
      check("underflow_y", 32'(o_y), 32'h0BB);
      check("underflow_cand", 32'(o_candidate), 32'h03);
      tick();
      exp_count = exp_count + 16'd1;
      check("underflow_sent", 32'(o_result_sent), 32'd1);
      check("underflow_count", 32'(o_record_count), 32'(exp_count));
      tick();
      ready = 1'b0;
   endtask

   task automatic async_reset_mid_record();
      bit bad;
      push(12'h111);
      push(12'h222);
      push(12'h01A);
      ready             = 1'b1;
      ready_send_result = 1'b1;
      tick();
      ready_send_result = 1'b0;
      tick();
      tick();
      tick();
      check("rst_precond_busy", 32'(o_busy), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("rst_trig", 32'(o_trig_send_result), 32'd0);
      check("rst_sent", 32'(o_result_sent), 32'd0);
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_x", 32'(o_x), 32'd0);
      check("rst_y", 32'(o_y), 32'd0);
      check("rst_cand", 32'(o_candidate), 32'd0);
      check("rst_count", 32'(o_record_count), 32'd0);
      push_cnt  = pop_cnt;
      exp_count = '0;
      tick();
      tick();
      reset = 1'b1;
      bad   = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         if (o_result_sent || o_busy || o_trig_send_result) bad = 1'b0 | 1'b1;
      end
      check("rst_release_idle", 32'(bad), 32'd0);
      ready = 1'b0;
   endtask

   task automatic random_test();
      localparam int N = 25;
      logic [11:0] rx [N];
      logic [11:0] ry [N];
      logic [11:0] rw [N];
      int          got = 0;
      int          cyc = 0;
      bit          hs_pending = 1'b0;
      for (int i = 0; i < N; i++) begin
         rx[i] = 12'($urandom_range(0, 4095));
         ry[i] = 12'($urandom_range(0, 4095));
         rw[i] = 12'($urandom_range(0, 4095));
      end
      fork
         begin
            for (int i = 0; i < N; i++) begin
               repeat ($urandom_range(0, 4)) tick();
               push(rx[i]);
               repeat ($urandom_range(0, 4)) tick();
               push(ry[i]);
               repeat ($urandom_range(0, 4)) tick();
               push(rw[i]);
            end
         end
         begin
            while ((got < N || hs_pending) && cyc < 3000) begin
               if (hs_pending) begin
                  check("rnd_sent", 32'(o_result_sent), 32'd1);
                  check("rnd_count", 32'(o_record_count), 32'(exp_count));
                  hs_pending = 1'b0;
               end else begin
                  check("rnd_no_sent", 32'(o_result_sent), 32'd0);
               end
               ready             = ($urandom_range(0, 9) < 7);
               ready_send_result = ($urandom_range(0, 9) < 8);
               if (o_valid && ready) begin
                  if (got < N) begin
                     check($sformatf("rnd%0d_x", got), 32'(o_x), 32'(rx[got]));
                     check($sformatf("rnd%0d_y", got), 32'(o_y), 32'(ry[got]));
                     check($sformatf("rnd%0d_cand", got), 32'(o_candidate), 32'(rw[got] % 12'd32));
                     got++;
                     exp_count  = exp_count + 16'd1;
                     hs_pending = 1'b1;
                  end else begin
                     check("rnd_extra_record", 32'(o_valid), 32'd0);
                  end
               end
               tick();
               cyc++;
            end
            check("rnd_all_records", 32'(got), 32'(N));
            ready             = 1'b0;
            ready_send_result = 1'b0;
         end
      join
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{x: 12'h123, y: 12'h045, w2: 12'h01F, hold: 0,  cand: 5'h1F};
      vecs[1] = '{x: 12'h7A0, y: 12'h0C3, w2: 12'hFE5, hold: 0,  cand: 5'h05};
      vecs[2] = '{x: 12'h456, y: 12'h789, w2: 12'h00C, hold: 20, cand: 5'h0C};
      vecs[3] = '{x: 12'hFFF, y: 12'hFFF, w2: 12'hFFF, hold: 3,  cand: 5'h1F};
      vecs[4] = '{x: 12'h000, y: 12'h000, w2: 12'h000, hold: 0,  cand: 5'h00};
      vecs[5] = '{x: 12'hABC, y: 12'h800, w2: 12'h020, hold: 1,  cand: 5'h00};

      reset             = 1'b0;
      ready_send_result = 1'b0;
      ready             = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_trig", 32'(o_trig_send_result), 32'd0);
      check("reset_valid", 32'(o_valid), 32'd0);
      check("reset_busy", 32'(o_busy), 32'd0);
      check("reset_count", 32'(o_record_count), 32'd0);
      check("reset_xyc", {o_x, o_y, 3'b000, o_candidate}, 32'd0);
      reset = 1'b1;
      tick();

      for (int i = 0; i < 6; i++) run_record(vecs[i], i);

      partial_underflow();
      async_reset_mid_record();

      // Preset the counter just below wrap, then deliver one record
      dut.count_q = 16'hFFFF;
      exp_count   = 16'hFFFF;
      run_record(vecs[0], 6);
      check("wrap_count_zero", 32'(o_record_count), 32'd0);

      random_test();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
